// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the datapath and data_memory_ctrl.
// Ports (master = datapath side, slave = memory side):
//   WE, RE        write / read enables
//   byte_en       per-byte write mask, bit i covers write_data[8i+7:8i]
//   address       word address (full width is range-checked)
//   write_data    write data
//   read_data     registered read data
//   read_valid    one-cycle strobe, read_data updated this cycle
//   busy          post-reset clear in progress, requests ignored
//   addr_err      one-cycle strobe, previous request was out of range
interface data_memory_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 16
);
   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   logic                  WE;
   logic [BE_WIDTH-1:0]   byte_en;
   logic                  RE;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  read_valid;
   logic                  busy;
   logic                  addr_err;

   modport master (
      output WE, byte_en, RE, address, write_data,
      input  read_data, read_valid, busy, addr_err
   );

   modport slave (
      input  WE, byte_en, RE, address, write_data,
      output read_data, read_valid, busy, addr_err
   );
endinterface

// File: rtl/data_memory_ctrl.sv
// Single-port data memory with byte-lane writes, registered write-first
// read port, post-reset zeroing sequencer and out-of-range detection.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   data_memory_ctrl_if slave (request in, registered response out)
module data_memory_ctrl #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DEPTH      = 256
) (
   input  logic              clk,
   input  logic              rst,
   data_memory_ctrl_if.slave bus
);
   localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;
   localparam int unsigned IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned AEXT_WIDTH = ADDR_WIDTH + 1;
   localparam logic [AEXT_WIDTH-1:0] DEPTH_EXT = AEXT_WIDTH'(DEPTH);
   localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(DEPTH - 1);

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   state_t                state, state_next;
   logic [IDX_WIDTH-1:0]  clr_cnt, clr_cnt_next;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [DATA_WIDTH-1:0] read_data_q, read_data_next;
   logic                  read_valid_q, read_valid_next;
   logic                  addr_err_q, addr_err_next;
   logic                  busy_q, busy_next;

   logic                  in_range;
   logic [IDX_WIDTH-1:0]  req_idx;
   logic [DATA_WIDTH-1:0] old_word;
   logic [DATA_WIDTH-1:0] merged_word;

   logic                  mem_we;
   logic [IDX_WIDTH-1:0]  mem_idx;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // Range check on the full address so high bits never alias into the array.
   assign in_range = {1'b0, bus.address} < DEPTH_EXT;
   assign req_idx  = bus.address[IDX_WIDTH-1:0];

   // Old word with the enabled write lanes overlaid; doubles as the
   // write-first read value for a same-edge read/write.
   always_comb begin
      old_word    = mem[req_idx];
      merged_word = old_word;
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
         if (bus.WE && bus.byte_en[i]) begin
            merged_word[8*i +: 8] = bus.write_data[8*i +: 8];
         end
      end
   end

   // Next-state, memory write port and next response values.
   always_comb begin
      state_next      = state;
      clr_cnt_next    = clr_cnt;
      busy_next       = 1'b0;
      read_data_next  = read_data_q;
      read_valid_next = 1'b0;
      addr_err_next   = 1'b0;
      mem_we          = 1'b0;
      mem_idx         = req_idx;
      mem_wdata       = merged_word;

      unique case (state)
         CLEAR: begin
            // Requests are ignored; zero one word per cycle.
            busy_next    = 1'b1;
            mem_we       = 1'b1;
            mem_idx      = clr_cnt;
            mem_wdata    = '0;
            clr_cnt_next = clr_cnt + 1'b1;
            if (clr_cnt == LAST_IDX) begin
               state_next = IDLE;
               busy_next  = 1'b0;
            end
         end
         IDLE: begin
            if (bus.WE || bus.RE) begin
               addr_err_next = !in_range;
               mem_we        = bus.WE && in_range;
               if (bus.RE) begin
                  read_valid_next = 1'b1;
                  read_data_next  = in_range ? merged_word : '0;
               end
            end
         end
      endcase
   end

   // State and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= CLEAR;
         clr_cnt      <= '0;
         busy_q       <= 1'b1;
         read_data_q  <= '0;
         read_valid_q <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         state        <= state_next;
         clr_cnt      <= clr_cnt_next;
         busy_q       <= busy_next;
         read_data_q  <= read_data_next;
         read_valid_q <= read_valid_next;
         addr_err_q   <= addr_err_next;
      end
   end

   // Storage array; the reset edge itself leaves contents untouched.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) begin
         mem[mem_idx] <= mem_wdata;
      end
   end

   assign bus.read_data  = read_data_q;
   assign bus.read_valid = read_valid_q;
   assign bus.busy       = busy_q;
   assign bus.addr_err   = addr_err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl (DEPTH=8): directed scenarios
// plus randomized traffic against a behavioural reference model.
module tb_data_memory_ctrl;
   localparam int unsigned DW    = 16;
   localparam int unsigned AW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned BEW   = DW / 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   data_memory_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   data_memory_ctrl #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_err = 0;
   int n_chk = 0;

   // Reference model state.
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_busy;
   int            m_clr_ptr;
   logic [DW-1:0] m_rd;
   bit            m_rv;
   bit            m_ae;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one clock edge's worth of inputs to the model.
   task automatic model_edge(input bit r, input bit we, input bit re,
                             input logic [BEW-1:0] be, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd);
      bit ok;
      if (r) begin
         m_busy    = 1;
         m_clr_ptr = 0;
         m_rd      = '0;
         m_rv      = 0;
         m_ae      = 0;
      end else if (m_busy) begin
         m_mem[m_clr_ptr] = '0;
         if (m_clr_ptr == DEPTH - 1) m_busy = 0;
         m_clr_ptr++;
         m_rv = 0;
         m_ae = 0;
      end else begin
         ok   = int'(a) < DEPTH;
         m_ae = (we || re) && !ok;
         m_rv = re;
         if (we && ok) begin
            for (int i = 0; i < BEW; i++) begin
               if (be[i]) m_mem[a][8*i +: 8] = wd[8*i +: 8];
            end
         end
         if (re) m_rd = ok ? m_mem[a] : '0;
      end
   endtask

   // Drive inputs, take one edge, update the model and compare outputs.
   task automatic cycle(input bit r, input bit we, input bit re,
                        input logic [BEW-1:0] be, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd);
      rst            = r;
      bus.WE         = we;
      bus.RE         = re;
      bus.byte_en    = be;
      bus.address    = a;
      bus.write_data = wd;
      @(posedge clk);
      model_edge(r, we, re, be, a, wd);
      #1;
      check("busy", 64'(bus.busy), 64'(m_busy));
      check("read_valid", 64'(bus.read_valid), 64'(m_rv));
      check("addr_err", 64'(bus.addr_err), 64'(m_ae));
      check("read_data", 64'(bus.read_data), 64'(m_rd));
   endtask

   task automatic idle_cycle();
      cycle(0, 0, 0, '0, '0, '0);
   endtask

   task automatic rand_cycle(input bit r);
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, DEPTH + 1));
      if ($urandom_range(0, 9) == 0) a = AW'(DEPTH + $urandom_range(0, 40000));
      cycle(r, 1'($urandom), 1'($urandom), BEW'($urandom), a, DW'($urandom));
   endtask

   // Reset, then run the clear with random requests, counting busy cycles.
   task automatic reset_and_clear(input string tag);
      int n;
      n = 0;
      rand_cycle(1);
      if (bus.busy) n++;
      for (int k = 0; k < 3 * DEPTH && bus.busy; k++) begin
         rand_cycle(0);
         if (bus.busy) n++;
      end
      check(tag, 64'(n), 64'(DEPTH));
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         cycle(0, 0, 1, '0, AW'(i), '0);
         check(tag, 64'(bus.read_data), 64'h0);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.WE = 1'b0;
      bus.RE = 1'b0;
      bus.byte_en = '0;
      bus.address = '0;
      bus.write_data = '0;

      // Reset then clear, with garbage loaded beforehand.
      reset_and_clear("busy_len_init");
      for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, '1, AW'(i), DW'($urandom));
      reset_and_clear("busy_len_garbage");
      read_all_zero("clear_zero");

      // Write/read sequence.
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 2'b11, AW'(i), DW'(i + 1));
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 1, '0, AW'(i), '0);
         check("seq_read", 64'(bus.read_data), 64'(i + 1));
      end

      // Byte lanes.
      cycle(0, 1, 0, 2'b11, 16'd3, 16'hAABB);
      cycle(0, 1, 0, 2'b01, 16'd3, 16'h1122);
      cycle(0, 0, 1, '0, 16'd3, '0);
      check("byte_lane", 64'(bus.read_data), 64'hAA22);

      // Write-first collision.
      cycle(0, 1, 0, 2'b11, 16'd5, 16'h1234);
      cycle(0, 1, 1, 2'b10, 16'd5, 16'hBEEF);
      check("collision", 64'(bus.read_data), 64'hBE34);
      idle_cycle();
      check("collision_rv_drop", 64'(bus.read_valid), 64'h0);

      // Out of range.
      cycle(0, 1, 0, 2'b11, 16'd0, 16'h5A5A);
      cycle(0, 1, 0, 2'b11, 16'd8, 16'h7777);
      check("oor_wr_err", 64'(bus.addr_err), 64'h1);
      cycle(0, 0, 1, '0, 16'd8, '0);
      check("oor_rd_err", 64'(bus.addr_err), 64'h1);
      check("oor_rd_data", 64'(bus.read_data), 64'h0);
      cycle(0, 0, 1, '0, 16'd0, '0);
      check("oor_no_err", 64'(bus.addr_err), 64'h0);
      check("oor_mem0", 64'(bus.read_data), 64'h5A5A);
      cycle(0, 0, 1, '0, 16'h0100, '0);
      check("oor_alias", 64'(bus.read_data), 64'h0);

      // Reset mid-clear with requests while busy.
      rand_cycle(1);
      for (int i = 0; i < 3; i++) rand_cycle(0);
      reset_and_clear("busy_len_midclear");
      read_all_zero("midclear_zero");

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) rand_cycle($urandom_range(0, 99) == 0);
      for (int i = 0; i < 3 * DEPTH; i++) idle_cycle();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(0, 0, 1, '0, AW'(i), '0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
